// File: rtl/alu_rs_pkg.sv
// Shared widths and the entry record for the ALU reservation station.
package alu_rs_pkg;

  localparam int unsigned OP_W   = 8;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned PREG_W = 7;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] src1;
    logic              rdy1;
    logic [DATA_W-1:0] src2;
    logic              rdy2;
    logic [PREG_W-1:0] waddr;
    logic              wable;
  } rs_entry_t;

endpackage

// File: rtl/alu_rs_if.sv
// Dispatch, writeback-broadcast and issue signals of the ALU reservation station.
interface alu_rs_if;
  import alu_rs_pkg::*;

  logic [OP_W-1:0]   in_mic_op;
  logic [DATA_W-1:0] in_src1;
  logic              in_src1_able;
  logic [DATA_W-1:0] in_src2;
  logic              in_src2_able;
  logic [PREG_W-1:0] in_write_addr;
  logic              in_write_able;
  logic              in_valid;
  logic              rs_full;

  logic              wb1_valid;
  logic [PREG_W-1:0] wb1_addr;
  logic [DATA_W-1:0] wb1_data;
  logic              wb2_valid;
  logic [PREG_W-1:0] wb2_addr;
  logic [DATA_W-1:0] wb2_data;

  logic              issue_valid;
  logic              issue_accept;
  logic [OP_W-1:0]   issue_mic_op;
  logic [DATA_W-1:0] issue_src1;
  logic [DATA_W-1:0] issue_src2;
  logic [PREG_W-1:0] issue_write_addr;
  logic              issue_write_able;

  modport master (
    output in_mic_op, in_src1, in_src1_able, in_src2, in_src2_able,
    output in_write_addr, in_write_able, in_valid,
    output wb1_valid, wb1_addr, wb1_data, wb2_valid, wb2_addr, wb2_data,
    output issue_accept,
    input  rs_full, issue_valid, issue_mic_op, issue_src1, issue_src2,
    input  issue_write_addr, issue_write_able
  );

  modport slave (
    input  in_mic_op, in_src1, in_src1_able, in_src2, in_src2_able,
    input  in_write_addr, in_write_able, in_valid,
    input  wb1_valid, wb1_addr, wb1_data, wb2_valid, wb2_addr, wb2_data,
    input  issue_accept,
    output rs_full, issue_valid, issue_mic_op, issue_src1, issue_src2,
    output issue_write_addr, issue_write_able
  );

endinterface

// File: rtl/rs_wakeup_cmp.sv
// Compares one operand tag against both writeback buses; bus 1 wins on a double hit.
module rs_wakeup_cmp
  import alu_rs_pkg::*;
(
  input  logic [PREG_W-1:0] i_tag,
  input  logic              i_wb1_valid,
  input  logic [PREG_W-1:0] i_wb1_addr,
  input  logic [DATA_W-1:0] i_wb1_data,
  input  logic              i_wb2_valid,
  input  logic [PREG_W-1:0] i_wb2_addr,
  input  logic [DATA_W-1:0] i_wb2_data,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_data
);

  logic w_hit1;
  logic w_hit2;

  assign w_hit1 = i_wb1_valid && (i_wb1_addr == i_tag);
  assign w_hit2 = i_wb2_valid && (i_wb2_addr == i_tag);
  assign o_hit  = w_hit1 || w_hit2;
  assign o_data = w_hit1 ? i_wb1_data : i_wb2_data;

endmodule

// File: rtl/alu_rs.sv
// Age-ordered ALU reservation station: compacted entries, writeback snooping,
// oldest-ready issue and enqueue bypass from same-cycle broadcasts.
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic     i_clk,
  input  logic     i_rst_n,
  input  logic     i_rs_flash,
  alu_rs_if.slave  bus
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = IDX_W + 1;

  rs_entry_t         r_entries [DEPTH];
  logic [CNT_W-1:0]  r_count;

  rs_entry_t         w_ext  [DEPTH+1];
  rs_entry_t         w_next [DEPTH];
  rs_entry_t         w_new;
  rs_entry_t         w_sel_entry;
  logic [DEPTH-1:0]  w_hit1;
  logic [DEPTH-1:0]  w_hit2;
  logic [DATA_W-1:0] w_hdata1 [DEPTH];
  logic [DATA_W-1:0] w_hdata2 [DEPTH];
  logic              w_byp_hit1;
  logic              w_byp_hit2;
  logic [DATA_W-1:0] w_byp_data1;
  logic [DATA_W-1:0] w_byp_data2;
  logic              w_issue_valid;
  logic [IDX_W-1:0]  w_sel_idx;
  logic              w_full;
  logic              w_fire;
  logic              w_enq;
  logic [CNT_W-1:0]  w_enq_pos;

  for (genvar g = 0; g < DEPTH; g++) begin : g_wake
    rs_wakeup_cmp u_cmp1 (
      .i_tag       (r_entries[g].src1[PREG_W-1:0]),
      .i_wb1_valid (bus.wb1_valid),
      .i_wb1_addr  (bus.wb1_addr),
      .i_wb1_data  (bus.wb1_data),
      .i_wb2_valid (bus.wb2_valid),
      .i_wb2_addr  (bus.wb2_addr),
      .i_wb2_data  (bus.wb2_data),
      .o_hit       (w_hit1[g]),
      .o_data      (w_hdata1[g])
    );
    rs_wakeup_cmp u_cmp2 (
      .i_tag       (r_entries[g].src2[PREG_W-1:0]),
      .i_wb1_valid (bus.wb1_valid),
      .i_wb1_addr  (bus.wb1_addr),
      .i_wb1_data  (bus.wb1_data),
      .i_wb2_valid (bus.wb2_valid),
      .i_wb2_addr  (bus.wb2_addr),
      .i_wb2_data  (bus.wb2_data),
      .o_hit       (w_hit2[g]),
      .o_data      (w_hdata2[g])
    );
  end

  rs_wakeup_cmp u_byp1 (
    .i_tag       (bus.in_src1[PREG_W-1:0]),
    .i_wb1_valid (bus.wb1_valid),
    .i_wb1_addr  (bus.wb1_addr),
    .i_wb1_data  (bus.wb1_data),
    .i_wb2_valid (bus.wb2_valid),
    .i_wb2_addr  (bus.wb2_addr),
    .i_wb2_data  (bus.wb2_data),
    .o_hit       (w_byp_hit1),
    .o_data      (w_byp_data1)
  );

  rs_wakeup_cmp u_byp2 (
    .i_tag       (bus.in_src2[PREG_W-1:0]),
    .i_wb1_valid (bus.wb1_valid),
    .i_wb1_addr  (bus.wb1_addr),
    .i_wb1_data  (bus.wb1_data),
    .i_wb2_valid (bus.wb2_valid),
    .i_wb2_addr  (bus.wb2_addr),
    .i_wb2_data  (bus.wb2_data),
    .o_hit       (w_byp_hit2),
    .o_data      (w_byp_data2)
  );

  // Woken entries plus an empty sentinel slot so the shift-down can read index i+1.
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_ext[i] = r_entries[i];
      if (r_entries[i].valid && !r_entries[i].rdy1 && w_hit1[i]) begin
        w_ext[i].src1 = w_hdata1[i];
        w_ext[i].rdy1 = 1'b1;
      end
      if (r_entries[i].valid && !r_entries[i].rdy2 && w_hit2[i]) begin
        w_ext[i].src2 = w_hdata2[i];
        w_ext[i].rdy2 = 1'b1;
      end
    end
    w_ext[DEPTH] = '0;
  end

  always_comb begin
    w_new       = '0;
    w_new.valid = 1'b1;
    w_new.op    = bus.in_mic_op;
    w_new.src1  = (!bus.in_src1_able && w_byp_hit1) ? w_byp_data1 : bus.in_src1;
    w_new.rdy1  = bus.in_src1_able || w_byp_hit1;
    w_new.src2  = (!bus.in_src2_able && w_byp_hit2) ? w_byp_data2 : bus.in_src2;
    w_new.rdy2  = bus.in_src2_able || w_byp_hit2;
    w_new.waddr = bus.in_write_addr;
    w_new.wable = bus.in_write_able;
  end

  // Select uses registered ready bits only; scanning downward leaves the lowest index.
  always_comb begin
    w_issue_valid = 1'b0;
    w_sel_idx     = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (r_entries[i].valid && r_entries[i].rdy1 && r_entries[i].rdy2) begin
        w_issue_valid = 1'b1;
        w_sel_idx     = IDX_W'(i);
      end
    end
  end

  assign w_sel_entry = w_issue_valid ? r_entries[w_sel_idx] : '0;
  assign w_full      = (r_count == CNT_W'(DEPTH));
  assign w_fire      = w_issue_valid && bus.issue_accept;
  assign w_enq       = bus.in_valid && !w_full && !i_rs_flash;
  assign w_enq_pos   = r_count - CNT_W'(w_fire);

  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (w_fire && (IDX_W'(i) >= w_sel_idx)) begin
        w_next[i] = w_ext[i+1];
      end else begin
        w_next[i] = w_ext[i];
      end
      if (w_enq && (CNT_W'(i) == w_enq_pos)) begin
        w_next[i] = w_new;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) r_entries[i] <= '0;
      r_count <= '0;
    end else if (i_rs_flash) begin
      for (int i = 0; i < int'(DEPTH); i++) r_entries[i] <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) r_entries[i] <= w_next[i];
      r_count <= r_count + CNT_W'(w_enq) - CNT_W'(w_fire);
    end
  end

  assign bus.rs_full          = w_full;
  assign bus.issue_valid      = w_issue_valid;
  assign bus.issue_mic_op     = w_sel_entry.op;
  assign bus.issue_src1       = w_sel_entry.src1;
  assign bus.issue_src2       = w_sel_entry.src2;
  assign bus.issue_write_addr = w_sel_entry.waddr;
  assign bus.issue_write_able = w_sel_entry.wable;

endmodule

// File: tb/tb_alu_rs.sv
// Directed bench for alu_rs: issue, wakeup, bypass priority, full, compaction, flush, reset.
module tb_alu_rs;
  import alu_rs_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic flash;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_rs_if bus ();

  alu_rs #(.DEPTH(8)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rs_flash (flash),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_in();
    bus.in_valid      = 1'b0;
    bus.in_mic_op     = '0;
    bus.in_src1       = '0;
    bus.in_src1_able  = 1'b0;
    bus.in_src2       = '0;
    bus.in_src2_able  = 1'b0;
    bus.in_write_addr = '0;
    bus.in_write_able = 1'b0;
  endtask

  task automatic clr_wb();
    bus.wb1_valid = 1'b0;
    bus.wb1_addr  = '0;
    bus.wb1_data  = '0;
    bus.wb2_valid = 1'b0;
    bus.wb2_addr  = '0;
    bus.wb2_data  = '0;
  endtask

  task automatic drive_enq(input logic [7:0] op, input logic [31:0] s1, input logic a1,
                           input logic [31:0] s2, input logic a2, input logic [6:0] wa);
    bus.in_valid      = 1'b1;
    bus.in_mic_op     = op;
    bus.in_src1       = s1;
    bus.in_src1_able  = a1;
    bus.in_src2       = s2;
    bus.in_src2_able  = a2;
    bus.in_write_addr = wa;
    bus.in_write_able = 1'b1;
  endtask

  initial begin
    clr_in();
    clr_wb();
    bus.issue_accept = 1'b0;
    flash = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    chk("reset_full", 32'(bus.rs_full), 32'd0);
    chk("reset_ivalid", 32'(bus.issue_valid), 32'd0);
    chk("reset_src1", bus.issue_src1, 32'd0);
    chk("reset_op", 32'(bus.issue_mic_op), 32'd0);
    rst_n = 1'b1;

    // Both operands ready at dispatch
    drive_enq(8'h11, 32'd5, 1'b1, 32'd7, 1'b1, 7'h20);
    tick();
    clr_in();
    chk("simple_ivalid", 32'(bus.issue_valid), 32'd1);
    chk("simple_op", 32'(bus.issue_mic_op), 32'h11);
    chk("simple_src1", bus.issue_src1, 32'd5);
    chk("simple_src2", bus.issue_src2, 32'd7);
    chk("simple_waddr", 32'(bus.issue_write_addr), 32'h20);
    chk("simple_wable", 32'(bus.issue_write_able), 32'd1);
    bus.issue_accept = 1'b1;
    tick();
    bus.issue_accept = 1'b0;
    chk("simple_empty", 32'(bus.issue_valid), 32'd0);

    // Wakeup through Wb1
    drive_enq(8'h22, 32'h12, 1'b0, 32'd3, 1'b1, 7'h21);
    tick();
    clr_in();
    chk("wake_wait0", 32'(bus.issue_valid), 32'd0);
    tick();
    bus.wb1_valid = 1'b1;
    bus.wb1_addr  = 7'h12;
    bus.wb1_data  = 32'hDEAD;
    chk("wake_no_zero_lat", 32'(bus.issue_valid), 32'd0);
    tick();
    clr_wb();
    chk("wake_ivalid", 32'(bus.issue_valid), 32'd1);
    chk("wake_src1", bus.issue_src1, 32'hDEAD);
    chk("wake_src2", bus.issue_src2, 32'd3);
    bus.issue_accept = 1'b1;
    tick();
    bus.issue_accept = 1'b0;
    chk("wake_empty", 32'(bus.issue_valid), 32'd0);

    // Enqueue bypass, both buses hit: Wb1 wins
    drive_enq(8'h33, 32'h0A, 1'b0, 32'd9, 1'b1, 7'h22);
    bus.wb1_valid = 1'b1;
    bus.wb1_addr  = 7'h0A;
    bus.wb1_data  = 32'h66;
    bus.wb2_valid = 1'b1;
    bus.wb2_addr  = 7'h0A;
    bus.wb2_data  = 32'h55;
    tick();
    clr_in();
    clr_wb();
    chk("byp_ivalid", 32'(bus.issue_valid), 32'd1);
    chk("byp_src1", bus.issue_src1, 32'h66);
    bus.issue_accept = 1'b1;
    tick();
    bus.issue_accept = 1'b0;
    chk("byp_empty", 32'(bus.issue_valid), 32'd0);

    // Fill all eight entries waiting on tag 0x30
    for (int i = 0; i < 8; i++) begin
      drive_enq(8'(i), 32'h30, 1'b0, 32'(i), 1'b1, 7'(i));
      tick();
    end
    clr_in();
    chk("fill_full", 32'(bus.rs_full), 32'd1);
    chk("fill_ivalid", 32'(bus.issue_valid), 32'd0);
    drive_enq(8'hFF, 32'hAA, 1'b1, 32'hBB, 1'b1, 7'h7F);
    tick();
    clr_in();
    chk("ninth_full", 32'(bus.rs_full), 32'd1);
    chk("ninth_dropped", 32'(bus.issue_valid), 32'd0);
    bus.wb1_valid = 1'b1;
    bus.wb1_addr  = 7'h30;
    bus.wb1_data  = 32'h1000;
    tick();
    clr_wb();
    bus.issue_accept = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("order_valid%0d", i), 32'(bus.issue_valid), 32'd1);
      chk($sformatf("order_op%0d", i), 32'(bus.issue_mic_op), 32'(i));
      chk($sformatf("order_src1_%0d", i), bus.issue_src1, 32'h1000);
      chk($sformatf("order_src2_%0d", i), bus.issue_src2, 32'(i));
      tick();
      if (i == 0) chk("full_drop", 32'(bus.rs_full), 32'd0);
    end
    bus.issue_accept = 1'b0;
    chk("drain_ivalid", 32'(bus.issue_valid), 32'd0);
    chk("drain_full", 32'(bus.rs_full), 32'd0);

    // Issue from index 1 while enqueueing in the same cycle
    drive_enq(8'h40, 32'h31, 1'b0, 32'd0, 1'b1, 7'h40);
    tick();
    drive_enq(8'h41, 32'd1, 1'b1, 32'd2, 1'b1, 7'h41);
    tick();
    chk("mid_sel_op", 32'(bus.issue_mic_op), 32'h41);
    drive_enq(8'h42, 32'h32, 1'b0, 32'd4, 1'b1, 7'h42);
    bus.issue_accept = 1'b1;
    tick();
    clr_in();
    bus.issue_accept = 1'b0;
    chk("mid_none_ready", 32'(bus.issue_valid), 32'd0);
    bus.wb2_valid = 1'b1;
    bus.wb2_addr  = 7'h32;
    bus.wb2_data  = 32'h77;
    tick();
    clr_wb();
    chk("mid_new_op", 32'(bus.issue_mic_op), 32'h42);
    chk("mid_new_src1", bus.issue_src1, 32'h77);
    bus.wb1_valid = 1'b1;
    bus.wb1_addr  = 7'h31;
    bus.wb1_data  = 32'h88;
    tick();
    clr_wb();
    chk("mid_oldest_op", 32'(bus.issue_mic_op), 32'h40);
    chk("mid_oldest_src1", bus.issue_src1, 32'h88);
    bus.issue_accept = 1'b1;
    tick();
    chk("mid_second_op", 32'(bus.issue_mic_op), 32'h42);
    tick();
    bus.issue_accept = 1'b0;
    chk("mid_empty", 32'(bus.issue_valid), 32'd0);

    // Flush with five entries, plus enqueue and accept in the same cycle
    for (int i = 0; i < 5; i++) begin
      drive_enq(8'(8'h50 + i), 32'(i), 1'b1, 32'd1, 1'b1, 7'(i));
      tick();
    end
    drive_enq(8'h5F, 32'd0, 1'b1, 32'd0, 1'b1, 7'h5F);
    bus.issue_accept = 1'b1;
    flash = 1'b1;
    chk("flush_pre_ivalid", 32'(bus.issue_valid), 32'd1);
    tick();
    clr_in();
    bus.issue_accept = 1'b0;
    flash = 1'b0;
    chk("flush_ivalid", 32'(bus.issue_valid), 32'd0);
    chk("flush_full", 32'(bus.rs_full), 32'd0);
    for (int i = 0; i < 7; i++) begin
      drive_enq(8'(8'h60 + i), 32'd1, 1'b1, 32'd1, 1'b1, 7'(i));
      tick();
    end
    clr_in();
    chk("flush_count7", 32'(bus.rs_full), 32'd0);
    drive_enq(8'h67, 32'd1, 1'b1, 32'd1, 1'b1, 7'h7);
    tick();
    clr_in();
    chk("flush_count8", 32'(bus.rs_full), 32'd1);
    chk("refill_oldest", 32'(bus.issue_mic_op), 32'h60);

    // Reset mid-traffic
    bus.issue_accept = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    bus.issue_accept = 1'b0;
    chk("rst_ivalid", 32'(bus.issue_valid), 32'd0);
    chk("rst_full", 32'(bus.rs_full), 32'd0);
    chk("rst_src1", bus.issue_src1, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
